// File: rtl/timer_sched_pkg.sv
// Shared types for timer_sched: FSM states, timer register map, control bits, bus-cycle encoder.
// Pure definitions, no storage; latency and backpressure are owned by the importing modules.
package timer_sched_pkg;

    typedef enum logic [3:0] {
        IDLE, CLR0, WRP0, WRP1, WRP2, WRP3, SETTLE, CTRL, WAIT, STOP, CLR1, DONE
    } state_e;

    localparam logic [3:0] ADDR_STATUS  = 4'd0;
    localparam logic [3:0] ADDR_CONTROL = 4'd1;
    localparam logic [3:0] ADDR_PERIOD0 = 4'd2;
    localparam logic [3:0] ADDR_PERIOD1 = 4'd3;
    localparam logic [3:0] ADDR_PERIOD2 = 4'd4;
    localparam logic [3:0] ADDR_PERIOD3 = 4'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // One-shot start: interrupt enabled, continuous mode explicitly off.
    localparam logic [15:0] CMD_ONESHOT = ((16'd1 << CTRL_START) | (16'd1 << CTRL_ITO))
                                          & ~(16'd1 << CTRL_CONT);
    localparam logic [15:0] CMD_STOP    = 16'd1 << CTRL_STOP;

    typedef struct packed {
        logic        cs;
        logic        write_n;
        logic [3:0]  addr;
        logic [15:0] data;
    } tmr_bus_t;

    localparam tmr_bus_t BUS_IDLE = '{cs: 1'b0, write_n: 1'b1, addr: 4'd0, data: 16'd0};

    function automatic tmr_bus_t bus_wr(input logic [3:0] a, input logic [15:0] d);
        tmr_bus_t b;
        b = '{cs: 1'b1, write_n: 1'b0, addr: a, data: d};
        return b;
    endfunction

    function automatic tmr_bus_t bus_for(input state_e s, input logic [63:0] p);
        tmr_bus_t b;
        b = BUS_IDLE;
        case (s)
            CLR0, CLR1: b = bus_wr(ADDR_STATUS, 16'h0000);
            WRP0:       b = bus_wr(ADDR_PERIOD0, p[15:0]);
            WRP1:       b = bus_wr(ADDR_PERIOD1, p[31:16]);
            WRP2:       b = bus_wr(ADDR_PERIOD2, p[47:32]);
            WRP3:       b = bus_wr(ADDR_PERIOD3, p[63:48]);
            CTRL:       b = bus_wr(ADDR_CONTROL, CMD_ONESHOT);
            STOP:       b = bus_wr(ADDR_CONTROL, CMD_STOP);
            default:    b = BUS_IDLE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_sched_if.sv
// Avalon-MM write-only master link to the interval timer plus its irq line.
// Single-cycle zero-wait-state writes; no backpressure on this link.
interface timer_sched_if;
    logic [3:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_irq
    );

    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_irq
    );
endinterface

// File: rtl/timer_sched_rr_arbiter.sv
// Round-robin pick among pending requests, searching circularly from a registered pointer.
// Pick is combinational (0 cycles); pointer moves to adv_idx+1 on adv_vld; no backpressure.
module timer_sched_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_REQ-1:0] req,
    input  logic             adv_vld,
    input  logic [IDX_W-1:0] adv_idx,
    output logic             pick_vld,
    output logic [IDX_W-1:0] pick_idx
);
    logic [IDX_W-1:0] ptr_q;

    // Walk offsets from far to near so the closest pending slot wins.
    always_comb begin
        int slot;
        slot     = 0;
        pick_vld = 1'b0;
        pick_idx = ptr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            slot = int'(ptr_q) + i;
            if (slot >= N_REQ) slot = slot - N_REQ;
            if (req[slot]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(slot);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (adv_vld) begin
            ptr_q <= (adv_idx == IDX_W'(N_REQ - 1)) ? '0 : adv_idx + 1'b1;
        end
    end
endmodule

// File: rtl/timer_sched.sv
// Shares one Avalon interval timer among N_REQ one-shot delay requesters; TIMER_SCHED_CANCEL_EN adds cancel.
// Latency: req->first write 2, req->START 8, irq->done 2 cycles; requests wait (level held) while busy.
module timer_sched
    import timer_sched_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int PERIOD_W = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*PERIOD_W-1:0] req_period,
    output logic [N_REQ-1:0]          grant,
    output logic [N_REQ-1:0]          done,
    output logic                      busy,
`ifdef TIMER_SCHED_CANCEL_EN
    input  logic [N_REQ-1:0]          cancel,
    output logic [N_REQ-1:0]          cancelled,
`endif
    timer_sched_if.master             tmr
);
    localparam int IDX_W = $clog2(N_REQ);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, pick_idx;
    logic             pick_vld, cancel_hit, aborted_q, busy_q;
    logic [63:0]      period_q, period_sel;
    tmr_bus_t         bus_q;
    logic [N_REQ-1:0] grant_q, done_q;
`ifdef TIMER_SCHED_CANCEL_EN
    logic [N_REQ-1:0] cancelled_q;
`endif

    timer_sched_rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .adv_vld  (state_q == DONE),
        .adv_idx  (owner_q),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    // Zero-extend to the timer's 64 bits; a zero period would never fire, so force 1.
    always_comb begin
        period_sel = '0;
        period_sel[PERIOD_W-1:0] = req_period[int'(pick_idx) * PERIOD_W +: PERIOD_W];
        if (period_sel == '0) period_sel = 64'd1;
    end

`ifdef TIMER_SCHED_CANCEL_EN
    assign cancel_hit = cancel[owner_q]
                      && (state_q inside {CLR0, WRP0, WRP1, WRP2, WRP3, SETTLE, CTRL, WAIT})
                      && !(state_q == WAIT && tmr.tmr_irq);
`else
    assign cancel_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = CLR0;
            CLR0:    state_d = WRP0;
            WRP0:    state_d = WRP1;
            WRP1:    state_d = WRP2;
            WRP2:    state_d = WRP3;
            WRP3:    state_d = SETTLE;
            SETTLE:  state_d = CTRL;
            CTRL:    state_d = WAIT;
            WAIT:    if (tmr.tmr_irq) state_d = CLR1;
            STOP:    state_d = CLR1;
            CLR1:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cancel_hit) state_d = STOP;
    end

    // Outputs are loaded from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            period_q    <= '0;
            bus_q       <= BUS_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            aborted_q   <= 1'b0;
`ifdef TIMER_SCHED_CANCEL_EN
            cancelled_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bus_q   <= bus_for(state_d, period_q);
            busy_q  <= (state_d != IDLE);
            done_q  <= '0;
            if (state_q == IDLE && pick_vld) begin
                owner_q   <= pick_idx;
                period_q  <= period_sel;
                grant_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
                aborted_q <= 1'b0;
            end
            if (cancel_hit) aborted_q <= 1'b1;
            if (state_q == DONE) grant_q <= '0;
            if (state_d == DONE && !aborted_q) done_q[owner_q] <= 1'b1;
`ifdef TIMER_SCHED_CANCEL_EN
            cancelled_q <= '0;
            if (state_d == DONE && aborted_q) cancelled_q[owner_q] <= 1'b1;
`endif
        end
    end

    assign grant              = grant_q;
    assign done               = done_q;
    assign busy               = busy_q;
    assign tmr.tmr_address    = bus_q.addr;
    assign tmr.tmr_chipselect = bus_q.cs;
    assign tmr.tmr_write_n    = bus_q.write_n;
    assign tmr.tmr_writedata  = bus_q.data;
`ifdef TIMER_SCHED_CANCEL_EN
    assign cancelled          = cancelled_q;
`endif
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched with a behavioural one-shot timer slave and write log.
// Build with TIMER_SCHED_CANCEL_EN defined to also exercise cancel.
module tb_timer_sched;
    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] req_period;
    logic [3:0]   grant, done, cancel, cancelled;
    logic         busy;

    timer_sched_if bus ();

    timer_sched #(.N_REQ(4), .PERIOD_W(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .req_period (req_period),
        .grant      (grant),
        .done       (done),
        .busy       (busy),
`ifdef TIMER_SCHED_CANCEL_EN
        .cancel     (cancel),
        .cancelled  (cancelled),
`endif
        .tmr        (bus)
    );

`ifndef TIMER_SCHED_CANCEL_EN
    assign cancelled = '0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Timer slave model: counts P..0 after START, raises irq, status write clears it.
    logic [19:0] wr_log[$];
    int          wr_edge[$];
    int          start_edge = 0, irq_edge = 0;
    logic [63:0] tm_per, tm_cnt;
    logic        tm_run;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.tmr_irq <= 1'b0;
            tm_per      <= '0;
            tm_cnt      <= '0;
            tm_run      <= 1'b0;
        end else if (bus.tmr_chipselect && !bus.tmr_write_n) begin
            wr_log.push_back({bus.tmr_address, bus.tmr_writedata});
            wr_edge.push_back(cyc + 1);
            case (bus.tmr_address)
                4'd0: bus.tmr_irq <= 1'b0;
                4'd1: begin
                    if (bus.tmr_writedata[2]) begin
                        tm_cnt     <= tm_per;
                        tm_run     <= 1'b1;
                        start_edge <= cyc + 1;
                    end
                    if (bus.tmr_writedata[3]) tm_run <= 1'b0;
                end
                4'd2: tm_per[15:0]  <= bus.tmr_writedata;
                4'd3: tm_per[31:16] <= bus.tmr_writedata;
                4'd4: tm_per[47:32] <= bus.tmr_writedata;
                4'd5: tm_per[63:48] <= bus.tmr_writedata;
                default: ;
            endcase
        end else if (tm_run) begin
            if (tm_cnt == 0) begin
                bus.tmr_irq <= 1'b1;
                tm_run      <= 1'b0;
                irq_edge    <= cyc + 1;
            end else begin
                tm_cnt <= tm_cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_period(input int idx, input logic [31:0] val);
        req_period[idx*32 +: 32] = val;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = '0;
        cancel  = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_pulse(input int budget, output logic [3:0] hd, output logic [3:0] hc,
                              output int at);
        hd = '0;
        hc = '0;
        at = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((done | cancelled) != '0) begin
                hd = done;
                hc = cancelled;
                at = cyc;
                break;
            end
        end
    endtask

    logic [19:0] exp_t1[7] = '{20'h0_0000, 20'h2_0063, 20'h3_0000, 20'h4_0000,
                               20'h5_0000, 20'h1_0005, 20'h0_0000};

    initial begin
        logic [3:0] hd, hc;
        int at, lb, c0, extra;
        reset_n    = 1'b1;
        req        = '0;
        cancel     = '0;
        req_period = '0;
        @(negedge clk);
        do_reset();

        check("rst grant", grant, 4'h0);
        check("rst done", done, 4'h0);
        check("rst busy", busy, 1'b0);
        check("rst cs", bus.tmr_chipselect, 1'b0);
        check("rst write_n", bus.tmr_write_n, 1'b1);
        check("rst addr", bus.tmr_address, 4'h0);
        check("rst wdata", bus.tmr_writedata, 16'h0);

        // Single request, period 99.
        lb = wr_log.size();
        set_period(0, 99);
        req = 4'b0001;
        c0  = cyc;
        @(negedge clk);
        check("t1 grant", grant, 4'b0001);
        check("t1 busy", busy, 1'b1);
        wait_pulse(300, hd, hc, at);
        check("t1 done", hd, 4'b0001);
        check("t1 irq->done", at - irq_edge, 2);
        check("t1 expiry", start_edge - irq_edge + 100, 0 + start_edge - irq_edge + (irq_edge - start_edge));
        check("t1 expiry clocks", irq_edge - start_edge, 100);
        check("t1 first write lat", wr_edge[lb] - c0, 2);
        check("t1 start lat", start_edge - c0, 8);
        for (int k = 0; k < 7; k++) check($sformatf("t1 write%0d", k), wr_log[lb+k], exp_t1[k]);
        req = '0;
        @(negedge clk);
        check("t1 done one cycle", done, 4'h0);
        check("t1 grant cleared", grant, 4'h0);
        check("t1 idle", busy, 1'b0);

        // All four at once from pointer 0, then 1+0 together after the wrap.
        do_reset();
        for (int i = 0; i < 4; i++) set_period(i, 10);
        req = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_pulse(100, hd, hc, at);
            check($sformatf("t2 done%0d", k), hd, 4'b0001 << k);
            check($sformatf("t2 owner%0d", k), grant, 4'b0001 << k);
            req = req & ~hd;
        end
        extra = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done != '0) extra++;
        end
        check("t2 extra dones", extra, 0);
        req = 4'b0011;
        @(negedge clk);
        check("t2 wrap grant", grant, 4'b0001);
        wait_pulse(100, hd, hc, at);
        check("t2 wrap done0", hd, 4'b0001);
        req = req & ~hd;
        wait_pulse(100, hd, hc, at);
        check("t2 wrap done1", hd, 4'b0010);
        req = '0;
        @(negedge clk);

        // Period wider than one halfword.
        lb = wr_log.size();
        set_period(3, 32'h0001_2345);
        req = 4'b1000;
        wait_pulse(80000, hd, hc, at);
        check("t3 done", hd, 4'b1000);
        check("t3 p0", wr_log[lb+1], 20'h2_2345);
        check("t3 p1", wr_log[lb+2], 20'h3_0001);
        check("t3 p2", wr_log[lb+3], 20'h4_0000);
        check("t3 p3", wr_log[lb+4], 20'h5_0000);
        check("t3 expiry", irq_edge - start_edge, 74566);
        req = '0;
        @(negedge clk);

        // Zero period clamps to 1.
        lb = wr_log.size();
        set_period(1, 0);
        req = 4'b0010;
        wait_pulse(100, hd, hc, at);
        check("t4 done", hd, 4'b0010);
        check("t4 clamp", wr_log[lb+1], 20'h2_0001);
        check("t4 expiry", irq_edge - start_edge, 2);
        req = '0;
        @(negedge clk);

        // Reset while waiting, request still pending afterwards.
        set_period(0, 50);
        req = 4'b0001;
        repeat (12) @(negedge clk);
        check("t5 busy in wait", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("t5 rst grant", grant, 4'h0);
        check("t5 rst busy", busy, 1'b0);
        check("t5 rst cs", bus.tmr_chipselect, 1'b0);
        repeat (2) @(negedge clk);
        lb      = wr_log.size();
        reset_n = 1'b1;
        c0      = cyc;
        wait_pulse(200, hd, hc, at);
        check("t5 restart done", hd, 4'b0001);
        check("t5 restart clr0", wr_log[lb], 20'h0_0000);
        check("t5 restart lat", wr_edge[lb] - c0, 2);
        req = '0;
        @(negedge clk);

`ifdef TIMER_SCHED_CANCEL_EN
        // Cancel the owner while it waits.
        set_period(2, 200);
        req = 4'b0100;
        repeat (12) @(negedge clk);
        lb     = wr_log.size();
        cancel = 4'b0100;
        @(negedge clk);
        cancel = '0;
        wait_pulse(50, hd, hc, at);
        check("t6 cancelled", hc, 4'b0100);
        check("t6 no done", hd, 4'b0000);
        check("t6 stop write", wr_log[lb], 20'h1_0008);
        check("t6 clr write", wr_log[lb+1], 20'h0_0000);
        req = '0;
        @(negedge clk);

        // irq and cancel in the same WAIT cycle: irq wins.
        set_period(2, 20);
        req = 4'b0100;
        for (int n = 0; n < 100 && !bus.tmr_irq; n++) @(negedge clk);
        cancel = 4'b0100;
        @(negedge clk);
        cancel = '0;
        wait_pulse(50, hd, hc, at);
        check("t6 race done", hd, 4'b0100);
        check("t6 race no cancel", hc, 4'b0000);
        req = '0;
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Shares one 64-bit Avalon interval-timer peripheral among N hardware requesters, such as game-logic delay and cooldown generators.
- Round-robin arbitrates pending one-shot delay requests and programs the timer over its 16-bit Avalon-MM slave port.
- Waits for the timer irq, clears the timer status, then returns a done pulse to the owning requester.
- Sits between fabric logic and the timer slave, replacing software (Nios) servicing of the timer.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- PERIOD_W, 32, requested period width in bits (17..64); upper timer halfwords are zero-filled.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock, asynchronous assert, active-low.
- req  in  N_REQ  per-requester request level; held until done.
- req_period  in  N_REQ*PERIOD_W  packed periods; slice i belongs to requester i.
- grant  out  N_REQ  one-hot owner of the timer; held from arbitration until done.
- done  out  N_REQ  one-cycle pulse to the owner when its delay expires.
- busy  out  1  high in every state except IDLE.
- tmr_address  out  4  timer slave address.
- tmr_chipselect  out  1  timer chipselect.
- tmr_write_n  out  1  timer write strobe, active-low.
- tmr_writedata  out  16  timer write data.
- tmr_irq  in  1  timer interrupt.

Behaviour:
- Reset values: grant=0, done=0, busy=0, tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0, rr pointer=0, state=IDLE.
- All outputs are registered.
- Each timer access is one cycle: chipselect=1, write_n=0. The timer slave has zero wait states.
- IDLE: if any req bit is high, select the first requester at or after the rr pointer (circular search). Latch its period and set grant. Go to CLR0.
- CLR0: write addr 0 with data 0 to drop any stale timeout.
- WRP0..WRP3: write addr 2..5 with period halfwords [15:0], [31:16], [47:32], [63:48]. Bits at or above PERIOD_W write as 0.
- SETTLE: one idle bus cycle so the timer's force_reload clears before start.
- CTRL: write addr 1 with data 0x0005 (START=1, ITO=1, CONT=0; one-shot).
- WAIT: no bus activity until tmr_irq=1.
- CLR1: write addr 0 with data 0. This deasserts tmr_irq one cycle later.
- DONE: pulse done[owner] for one cycle, clear grant, set rr pointer to owner+1 mod N_REQ, go to IDLE.
- Expiry time: the timer counts P..0, so expiry occurs P+1 clocks after the start write. A period of 0 is clamped to 1.
- Latency: req rise to first bus write is 2 cycles (arbitrate in IDLE, register). req to START write is 8 cycles. irq to done pulse is 2 cycles.
- req deasserting while granted is ignored; the delay still completes and done still pulses.
- A new request is never granted in the DONE cycle. Arbitration occurs only in IDLE.
- tmr_irq seen in any state other than WAIT is ignored; CLR0 discards it.
- reset_n asserted mid-sequence: everything returns to reset values immediately. The timer is reset by the same reset_n.

Optional Feature:
- Macro: TIMER_SCHED_CANCEL_EN.
- With the macro defined:
  - Adds input cancel [N_REQ] and output cancelled [N_REQ].
  - cancel[owner]=1 in any state from CLR0..WAIT goes to STOP: write addr 1 with data 0x0008 (STOP), then CLR1.
  - The cancelled[owner] pulse replaces done. The rr pointer advances.
  - cancel to a non-owner is ignored.
  - If cancel and tmr_irq arrive in the same WAIT cycle, irq wins and done pulses.
- Without the macro: no cancel ports; every grant ends in done.

Decomposition:
- Package timer_sched_pkg holds:
  - state enum (IDLE, CLR0, WRP0..WRP3, SETTLE, CTRL, WAIT, STOP, CLR1, DONE).
  - timer register address constants (STATUS=0, CONTROL=1, PERIODL=2..5).
  - control bit constants (ITO=0, CONT=1, START=2, STOP=3).
- Sub-module rr_arbiter (combinational round-robin pick plus pointer register) is instantiated once.

Test Plan:
- Single request, req0 with period 99. Expect bus writes CLR0, 0x0063@2, 0@3, 0@4, 0@5, 0x0005@1. Timer irq 100 clocks after the start write. done[0] 2 cycles after irq.
- req0..req3 all high simultaneously, periods 10. Expect grants in order 0,1,2,3 with exactly one done each. Then raise req1 and req0 together with pointer=0: expect grant 0.
- Period 0x0001_2345 (PERIOD_W=32). Expect writes 0x2345@2, 0x0001@3, 0@4, 0@5. Expiry 74566 clocks after start.
- Period 0. Expect 0x0001 written to addr 2 and done pulsed.
- Assert reset_n low during WAIT. Expect grant=0, busy=0, bus idle. After release, a pending req restarts from CLR0.
- With TIMER_SCHED_CANCEL_EN, cancel[2] in WAIT. Expect write 0x0008@1, then 0@0, then cancelled[2] pulse and no done[2]. Same-cycle irq and cancel: expect done[2].
